// File: rtl/checker_axi_lite_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : checker_axi_lite_master_bridge_if
// Brief    : AXI4-Lite bus bundle between the bridge (master) and a CSR slave.
// Revision : 1.0 - initial release
// ============================================================================
interface checker_axi_lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = (DATA_WIDTH + 7) / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/checker_axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : checker_axi_lite_master_bridge
// Brief    : Single-outstanding local-bus to AXI4-Lite master with timeout ack.
// Revision : 1.0 - initial release
// ============================================================================
module checker_axi_lite_master_bridge #(
  parameter int                    ADDR_WIDTH     = 17,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    STRB_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] local_addr,
  input  logic                  local_wr_en,
  input  logic [DATA_WIDTH-1:0] local_wr_data,
  input  logic [STRB_WIDTH-1:0] local_wr_strb,
  output logic                  local_wr_ack,
  input  logic                  local_rd_en,
  output logic [DATA_WIDTH-1:0] local_rd_data,
  output logic                  local_rd_ack,
  output logic                  local_err,
  output logic                  local_busy,
  output logic                  local_req_drop,
  checker_axi_lite_master_bridge_if.master m_axi
);

  localparam int                c_CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit                c_TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT_CYCLES > 0) ?
                                             c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                r_state,     w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic [STRB_WIDTH-1:0] r_wstrb,     w_wstrb_nxt;
  logic                  r_awvalid,   w_awvalid_nxt;
  logic                  r_wvalid,    w_wvalid_nxt;
  logic                  r_bready,    w_bready_nxt;
  logic                  r_arvalid,   w_arvalid_nxt;
  logic                  r_rready,    w_rready_nxt;
  logic                  r_wr_ack,    w_wr_ack_nxt;
  logic                  r_rd_ack,    w_rd_ack_nxt;
  logic                  r_err,       w_err_nxt;
  logic                  r_drop,      w_drop_nxt;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rd_data,   w_rd_data_nxt;
  logic [c_CNT_W-1:0]    r_cnt,       w_cnt_nxt;
  logic                  r_timed_out, w_timed_out_nxt;
  logic                  w_resp_now;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_wr_ack_nxt    = 1'b0;
    w_rd_ack_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
    w_drop_nxt      = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_cnt_nxt       = r_cnt;
    w_timed_out_nxt = r_timed_out;
    w_resp_now      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_timed_out_nxt = 1'b0;
        if (local_wr_en) begin
          w_addr_nxt    = local_addr;
          w_wdata_nxt   = local_wr_data;
          w_wstrb_nxt   = local_wr_strb;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_cnt_nxt     = '0;
          w_drop_nxt    = local_rd_en;
          w_state_nxt   = S_WR;
        end else if (local_rd_en) begin
          w_addr_nxt    = local_addr;
          w_arvalid_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_RD;
        end
      end
      S_WR: begin
        // AW and W retire independently; WRESP only once both are gone.
        w_awvalid_nxt = r_awvalid & ~m_axi.awready;
        w_wvalid_nxt  = r_wvalid & ~m_axi.wready;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (m_axi.bvalid) begin
          w_resp_now   = 1'b1;
          w_bready_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
          if (!r_timed_out) begin
            w_wr_ack_nxt = 1'b1;
            w_err_nxt    = (m_axi.bresp != 2'b00);
          end
        end
      end
      S_RD: begin
        if (m_axi.arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi.rvalid) begin
          w_resp_now   = 1'b1;
          w_rready_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
          if (!r_timed_out) begin
            w_rd_ack_nxt  = 1'b1;
            w_rd_data_nxt = m_axi.rdata;
            w_err_nxt     = (m_axi.rresp != 2'b00);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (r_state != S_IDLE) begin
      w_drop_nxt = local_wr_en | local_rd_en;
      if (!r_timed_out) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      // A response arriving on the deadline cycle pre-empts the forced ack.
      if (c_TO_EN && !r_timed_out && !w_resp_now && (r_cnt == c_CNT_LAST)) begin
        w_timed_out_nxt = 1'b1;
        w_err_nxt       = 1'b1;
        if ((r_state == S_WR) || (r_state == S_WRESP)) begin
          w_wr_ack_nxt = 1'b1;
        end else begin
          w_rd_ack_nxt  = 1'b1;
          w_rd_data_nxt = TIMEOUT_RDATA;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_data   <= '0;
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_wr_ack    <= w_wr_ack_nxt;
      r_rd_ack    <= w_rd_ack_nxt;
      r_err       <= w_err_nxt;
      r_drop      <= w_drop_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rd_data   <= w_rd_data_nxt;
      r_cnt       <= w_cnt_nxt;
      r_timed_out <= w_timed_out_nxt;
    end
  end

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

  assign local_wr_ack   = r_wr_ack;
  assign local_rd_ack   = r_rd_ack;
  assign local_rd_data  = r_rd_data;
  assign local_err      = r_err;
  assign local_busy     = r_busy;
  assign local_req_drop = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_checker_axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_checker_axi_lite_master_bridge
// Brief    : Randomized bench with a cycle-arithmetic reference model of the bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_checker_axi_lite_master_bridge;

  localparam int c_TO    = 16;
  localparam int c_LIMIT = 40;

  logic        aclk = 1'b0;
  logic        resetn;
  logic [16:0] local_addr;
  logic        local_wr_en;
  logic [31:0] local_wr_data;
  logic [3:0]  local_wr_strb;
  logic        local_wr_ack;
  logic        local_rd_en;
  logic [31:0] local_rd_data;
  logic        local_rd_ack;
  logic        local_err;
  logic        local_busy;
  logic        local_req_drop;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd  = 32'h0;

  checker_axi_lite_master_bridge_if #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) axi ();

  checker_axi_lite_master_bridge #(
    .ADDR_WIDTH     (17),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (c_TO)
  ) dut (
    .aclk           (aclk),
    .resetn         (resetn),
    .local_addr     (local_addr),
    .local_wr_en    (local_wr_en),
    .local_wr_data  (local_wr_data),
    .local_wr_strb  (local_wr_strb),
    .local_wr_ack   (local_wr_ack),
    .local_rd_en    (local_rd_en),
    .local_rd_data  (local_rd_data),
    .local_rd_ack   (local_rd_ack),
    .local_err      (local_err),
    .local_busy     (local_busy),
    .local_req_drop (local_req_drop),
    .m_axi          (axi)
  );

  always #5 aclk = ~aclk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'h0;
    axi.rresp   = 2'b00;
  endtask

  // One local request against a slave with the given wait states; cycle 0 is the
  // request cycle. Expected timing is derived from the handshake arithmetic alone.
  task automatic run_txn(input bit is_wr, input bit both, input int poke,
                         input logic [16:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int da, input int dw,
                         input int db, input logic [1:0] resp, input logic [31:0] rdata);
    int          exp_r, exp_ack_t, exp_drop;
    logic        exp_err;
    logic [31:0] exp_data;
    int          aw_age, w_age, ar_age, aw_hs, w_hs, ar_hs, resp_at;
    int          n_ack, ack_t, n_drop, busy_rel, aw_cyc, w_cyc, ar_cyc;
    logic        got_err, got_wr;
    logic [31:0] got_data, got_wdata;
    logic [16:0] got_addr;
    logic [3:0]  got_wstrb;
    bit          rsp_done;

    exp_r = is_wr ? 2 + ((da > dw) ? da : dw) + db : 2 + da + db;
    if (exp_r <= c_TO) begin
      exp_ack_t = exp_r + 1;
      exp_err   = (resp != 2'b00);
      exp_data  = rdata;
    end else begin
      exp_ack_t = c_TO + 1;
      exp_err   = 1'b1;
      exp_data  = 32'hDEAD_BEEF;
    end
    exp_drop = int'(is_wr && both) + int'(poke > 0);

    aw_age = 0; w_age = 0; ar_age = 0; aw_hs = -1; w_hs = -1; ar_hs = -1; resp_at = -1;
    n_ack = 0; ack_t = -1; n_drop = 0; busy_rel = -1; aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
    got_err = 1'b0; got_wr = 1'b0; got_data = '0; got_wdata = '0; got_addr = '0;
    got_wstrb = '0; rsp_done = 1'b0;

    for (int t = 0; t < c_LIMIT; t++) begin
      if (t > 0) @(negedge aclk);
      local_addr    = addr;
      local_wr_data = data;
      local_wr_strb = strb;
      local_wr_en   = (t == 0) && is_wr;
      local_rd_en   = ((t == 0) && (!is_wr || both)) || (t == poke);

      if (local_wr_ack || local_rd_ack) begin
        n_ack++;
        ack_t    = t;
        got_err  = local_err;
        got_wr   = local_wr_ack;
        got_data = local_rd_data;
      end
      if (local_req_drop) n_drop++;
      if (t > 0 && busy_rel < 0 && !local_busy) busy_rel = t;
      if (axi.awvalid) aw_cyc++;
      if (axi.wvalid)  w_cyc++;
      if (axi.arvalid) ar_cyc++;

      axi.awready = axi.awvalid && (aw_age == da);
      if (axi.awvalid) begin
        if (axi.awready) begin aw_hs = t; got_addr = axi.awaddr; end
        aw_age++;
      end
      axi.wready = axi.wvalid && (w_age == dw);
      if (axi.wvalid) begin
        if (axi.wready) begin w_hs = t; got_wdata = axi.wdata; got_wstrb = axi.wstrb; end
        w_age++;
      end
      axi.arready = axi.arvalid && (ar_age == da);
      if (axi.arvalid) begin
        if (axi.arready) begin ar_hs = t; got_addr = axi.araddr; end
        ar_age++;
      end

      axi.bresp  = resp;
      axi.bvalid = is_wr && !rsp_done && aw_hs >= 0 && w_hs >= 0 &&
                   t >= ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + db;
      if (axi.bvalid && axi.bready) begin resp_at = t; rsp_done = 1'b1; end

      axi.rresp  = resp;
      axi.rvalid = !is_wr && !rsp_done && ar_hs >= 0 && t >= ar_hs + 1 + db;
      axi.rdata  = axi.rvalid ? rdata : $urandom;
      if (axi.rvalid && axi.rready) begin resp_at = t; rsp_done = 1'b1; end
    end

    local_wr_en = 1'b0;
    local_rd_en = 1'b0;
    slave_idle();

    check_value("ack_count",    n_ack,    1);
    check_value("ack_cycle",    ack_t,    exp_ack_t);
    check_value("ack_kind",     got_wr,   is_wr);
    check_value("ack_err",      got_err,  exp_err);
    check_value("resp_cycle",   resp_at,  exp_r);
    check_value("busy_release", busy_rel, exp_r + 1);
    check_value("req_drops",    n_drop,   exp_drop);
    check_value("bus_addr",     got_addr, addr);
    if (is_wr) begin
      check_value("aw_cycles", aw_cyc,    da + 1);
      check_value("w_cycles",  w_cyc,     dw + 1);
      check_value("ar_cycles", ar_cyc,    0);
      check_value("wdata",     got_wdata, data);
      check_value("wstrb",     got_wstrb, strb);
    end else begin
      check_value("ar_cycles", ar_cyc,    da + 1);
      check_value("aw_cycles", aw_cyc + w_cyc, 0);
      check_value("rd_data",   got_data,  exp_data);
      last_rd = exp_data;
    end
    check_value("rd_data_hold", local_rd_data, last_rd);
  endtask

  task automatic reset_mid_write();
    int n_ack;
    n_ack = 0;
    slave_idle();
    local_addr    = 17'h00ABC;
    local_wr_data = 32'h0BAD_F00D;
    local_wr_strb = 4'hF;
    local_wr_en   = 1'b1;
    @(negedge aclk);
    local_wr_en = 1'b0;
    check_value("rst_pre_awvalid", axi.awvalid, 1'b1);
    resetn = 1'b0;
    @(negedge aclk);
    resetn = 1'b1;
    check_value("rst_awvalid", axi.awvalid, 1'b0);
    check_value("rst_wvalid",  axi.wvalid,  1'b0);
    check_value("rst_arvalid", axi.arvalid, 1'b0);
    check_value("rst_busy",    local_busy,  1'b0);
    for (int i = 0; i < 6; i++) begin
      if (local_wr_ack || local_rd_ack) n_ack++;
      @(negedge aclk);
    end
    check_value("rst_no_ack",  n_ack, 0);
    check_value("rst_idle",    local_busy, 1'b0);
    last_rd = 32'h0;
  endtask

  initial begin
    resetn        = 1'b0;
    local_addr    = '0;
    local_wr_en   = 1'b0;
    local_wr_data = '0;
    local_wr_strb = '0;
    local_rd_en   = 1'b0;
    slave_idle();
    repeat (3) @(negedge aclk);

    check_value("reset_busy",    local_busy,     1'b0);
    check_value("reset_awvalid", axi.awvalid,    1'b0);
    check_value("reset_wvalid",  axi.wvalid,     1'b0);
    check_value("reset_arvalid", axi.arvalid,    1'b0);
    check_value("reset_bready",  axi.bready,     1'b0);
    check_value("reset_rready",  axi.rready,     1'b0);
    check_value("reset_acks",    {local_wr_ack, local_rd_ack, local_err, local_req_drop}, 4'b0);
    check_value("reset_rd_data", local_rd_data,  32'h0);
    check_value("reset_addr",    axi.awaddr,     17'h0);
    check_value("prot_zero",     {axi.awprot, axi.arprot}, 6'b0);
    resetn = 1'b1;
    @(negedge aclk);

    run_txn(1'b1, 1'b0, -1, 17'h00010, 32'hA5A5_0001, 4'hF, 0, 0, 0,  2'b00, 32'h0);
    run_txn(1'b1, 1'b0, -1, 17'h00124, 32'h1111_2222, 4'h3, 1, 4, 1,  2'b10, 32'h0);
    run_txn(1'b0, 1'b0, -1, 17'h1FFFC, 32'h0,         4'h0, 5, 0, 0,  2'b00, 32'h1234_5678);
    run_txn(1'b1, 1'b1,  2, 17'h00200, 32'hCAFE_0002, 4'hC, 0, 1, 0,  2'b00, 32'h0);
    run_txn(1'b0, 1'b0, -1, 17'h00300, 32'h0,         4'h0, 0, 0, 20, 2'b00, 32'h5555_AAAA);
    run_txn(1'b0, 1'b0, -1, 17'h00304, 32'h0,         4'h0, 0, 0, 14, 2'b01, 32'h7777_0003);
    run_txn(1'b1, 1'b0,  1, 17'h00308, 32'h0000_0004, 4'hF, 0, 0, 15, 2'b00, 32'h0);
    run_txn(1'b1, 1'b0, -1, 17'h0030C, 32'h0000_0005, 4'hF, 2, 0, 12, 2'b11, 32'h0);

    for (int n = 0; n < 40; n++) begin
      bit is_wr;
      is_wr = $urandom_range(0, 1) == 1;
      run_txn(is_wr,
              is_wr && ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : -1,
              17'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
              $urandom);
    end

    reset_mid_write();
    run_txn(1'b0, 1'b0, -1, 17'h00044, 32'h0, 4'h0, 1, 0, 2, 2'b00, 32'h9ABC_DEF0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
